vga_hvsync_generator: RTL and testbench

VGA_HVSYNC_GENERATOR -- requirements
Module: vga_hvsync_generator

---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_hvsync_generator.sv | 77 +++++++
 tb/tb_vga_hvsync_generator.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing defaults (640x480 @ 60 Hz, 25.175 MHz pixel clock) and the
// derived last-count values for the horizontal and vertical counters.
// Also provides a small inclusive-window decode helper used by the sync logic.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks.
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    // Vertical timing, in lines.
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_BOTTOM_DEF  = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_TOP_DEF     = 33;

    // Last value of each counter before it wraps (799 and 524 by default).
    localparam int H_MAX_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF - 1;
    localparam int V_MAX_DEF = V_DISPLAY_DEF + V_BOTTOM_DEF + V_SYNC_DEF + V_TOP_DEF - 1;

    // True when lo <= pos <= hi (inclusive window).
    function automatic logic in_window(input logic [9:0] pos, input int lo, input int hi);
        return (int'(pos) >= lo) && (int'(pos) <= hi);
    endfunction

endpackage

// File: rtl/vga_hvsync_generator.sv
// ----------------------------------------------------------------------------
// vga_hvsync_generator
// Free-running VGA raster position counters with sync and blanking decodes.
//
// Ports
//   clk        in   pixel clock, all state on its rising edge
//   reset      in   synchronous active-high reset, forces position (0,0)
//   hsync      out  horizontal sync, active-low
//   vsync      out  vertical sync, active-low
//   display_on out  high while (hpos,vpos) lies in the visible area
//   hpos       out  [9:0] current pixel column, 0..H_MAX
//   vpos       out  [9:0] current line, 0..V_MAX
//
// The decodes are combinational from the registered counters, so the sync and
// blanking outputs always describe exactly the position presented on
// hpos/vpos in the same cycle.
// ----------------------------------------------------------------------------
module vga_hvsync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_BOTTOM  = V_BOTTOM_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_TOP     = V_TOP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int H_MAX_I = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX_I = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

    localparam logic [9:0] H_MAX    = 10'(H_MAX_I);
    localparam logic [9:0] V_MAX    = 10'(V_MAX_I);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);

    // Sync pulses sit after the front porch.
    localparam int HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int HS_LAST  = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_FIRST = V_DISPLAY + V_BOTTOM;
    localparam int VS_LAST  = V_DISPLAY + V_BOTTOM + V_SYNC - 1;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (hpos == H_MAX);
    assign v_wrap = (vpos == V_MAX);

    // The line counter advances only on the clock where the pixel counter
    // wraps, so both counters change together on the last pixel of a line.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos <= '0;
            vpos <= '0;
        end else if (h_wrap) begin
            hpos <= '0;
            vpos <= v_wrap ? '0 : vpos + 10'd1;
        end else begin
            hpos <= hpos + 10'd1;
        end
    end

    assign hsync      = ~in_window(hpos, HS_FIRST, HS_LAST);
    assign vsync      = ~in_window(vpos, VS_FIRST, VS_LAST);
    assign display_on = (hpos < H_VIS) && (vpos < V_VIS);

endmodule

// File: tb/tb_vga_hvsync_generator.sv
// ----------------------------------------------------------------------------
// tb_vga_hvsync_generator
// Bench for vga_hvsync_generator. Instance "a" uses the default 640x480
// timing for line-level behaviour; instance "b" uses a shrunken timing so the
// vertical sync, frame blanking and frame wrap can be exercised in a few
// hundred clocks. Expected outputs come from the elapsed-clocks-since-reset
// count of each instance, turned into a raster position with division and
// modulo.
// ----------------------------------------------------------------------------
module tb_vga_hvsync_generator;

    // Default timing (instance a).
    localparam int AHD = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVD = 480, AVB = 10, AVS = 2,  AVT = 33;
    localparam int A_LINE = AHD + AHF + AHS + AHB;          // 800

    // Small timing (instance b).
    localparam int BHD = 16, BHF = 2, BHS = 4, BHB = 3;
    localparam int BVD = 8,  BVB = 2, BVS = 2, BVT = 3;
    localparam int B_LINE  = BHD + BHF + BHS + BHB;         // 25
    localparam int B_LINES = BVD + BVB + BVS + BVT;         // 15
    localparam int B_FRAME = B_LINE * B_LINES;              // 375

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       hsync_a, vsync_a, de_a, hsync_b, vsync_b, de_b;
    logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;

    int total = 0;
    int bad   = 0;

    // Clocks elapsed since each instance last saw reset.
    longint ta = 0;
    longint tb = 0;

    always #5 clk = ~clk;

    vga_hvsync_generator u_a (
        .clk(clk), .reset(rst_a), .hsync(hsync_a), .vsync(vsync_a),
        .display_on(de_a), .hpos(hpos_a), .vpos(vpos_a)
    );

    vga_hvsync_generator #(
        .H_DISPLAY(BHD), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_DISPLAY(BVD), .V_BOTTOM(BVB), .V_SYNC(BVS), .V_TOP(BVT)
    ) u_b (
        .clk(clk), .reset(rst_b), .hsync(hsync_b), .vsync(vsync_b),
        .display_on(de_b), .hpos(hpos_b), .vpos(vpos_b)
    );

    always @(posedge clk) begin
        ta <= rst_a ? 64'sd0 : ta + 1;
        tb <= rst_b ? 64'sd0 : tb + 1;
    end

    // Reference: {hpos, vpos, hsync, vsync, display_on} after t clocks.
    function automatic logic [22:0] model(input longint t,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vb, input int vs, input int vt);
        longint line, lines, h, v;
        logic   hs_n, vs_n, de;
        line  = hd + hf + hs + hb;
        lines = vd + vb + vs + vt;
        h     = t % line;
        v     = (t / line) % lines;
        hs_n  = !(h >= hd + hf && h < hd + hf + hs);
        vs_n  = !(v >= vd + vb && v < vd + vb + vs);
        de    = (h < hd) && (v < vd);
        return {10'(h), 10'(v), hs_n, vs_n, de};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] got;
        repeat (1000 + $urandom_range(0, 600)) tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {hpos_a, vpos_a, hsync_a, vsync_a, de_a};
            total++;
            if (got !== {10'd0, 10'd0, 3'b111}) begin
                bad++;
                $display("FAIL reset_a cycle %0d: got %h expected %h", i, got, {10'd0, 10'd0, 3'b111});
            end
            got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
            total++;
            if (got !== {10'd0, 10'd0, 3'b111}) begin
                bad++;
                $display("FAIL reset_b cycle %0d: got %h expected %h", i, got, {10'd0, 10'd0, 3'b111});
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        got = {hpos_a, vpos_a, hsync_a, vsync_a, de_a};
        total++;
        if (got !== {10'd1, 10'd0, 3'b111}) begin
            bad++;
            $display("FAIL reset_release: got %h expected %h", got, {10'd1, 10'd0, 3'b111});
        end
    endtask

    task automatic test_line_wrap();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        repeat (A_LINE - 1) tick();
        total++;
        if (hpos_a !== 10'(A_LINE - 1) || vpos_a !== 10'd0) begin
            bad++;
            $display("FAIL line_end: got (%0d,%0d) expected (%0d,0)", hpos_a, vpos_a, A_LINE - 1);
        end
        tick();
        total++;
        if (hpos_a !== 10'd0 || vpos_a !== 10'd1) begin
            bad++;
            $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", hpos_a, vpos_a);
        end
    endtask

    task automatic test_hsync();
        int fall_h = -1, rise_h = -1, low = 0;
        logic prev = 1'b1;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int i = 0; i < A_LINE; i++) begin
            if (prev && !hsync_a && fall_h < 0) fall_h = int'(hpos_a);
            if (!prev && hsync_a && rise_h < 0) rise_h = int'(hpos_a);
            if (!hsync_a) low++;
            prev = hsync_a;
            tick();
        end
        total++;
        if (fall_h != AHD + AHF) begin
            bad++;
            $display("FAIL hsync_fall: got hpos %0d expected %0d", fall_h, AHD + AHF);
        end
        total++;
        if (rise_h != AHD + AHF + AHS) begin
            bad++;
            $display("FAIL hsync_rise: got hpos %0d expected %0d", rise_h, AHD + AHF + AHS);
        end
        total++;
        if (low != AHS) begin
            bad++;
            $display("FAIL hsync_width: got %0d expected %0d", low, AHS);
        end
    endtask

    task automatic test_display_on();
        int   cnt = 0, on_blank_line = 0;
        logic de_at_edge = 1'bx;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int i = 0; i < A_LINE; i++) begin
            if (de_a) cnt++;
            if (int'(hpos_a) == AHD) de_at_edge = de_a;
            tick();
        end
        total++;
        if (cnt != AHD) begin
            bad++;
            $display("FAIL de_line_count: got %0d expected %0d", cnt, AHD);
        end
        total++;
        if (de_at_edge !== 1'b0) begin
            bad++;
            $display("FAIL de_at_hpos_end: got %b expected 0", de_at_edge);
        end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < B_FRAME; i++) begin
            if (de_b) cnt++;
            if (int'(vpos_b) == BVD && de_b) on_blank_line++;
            tick();
        end
        total++;
        if (cnt != BHD * BVD) begin
            bad++;
            $display("FAIL de_frame_count: got %0d expected %0d", cnt, BHD * BVD);
        end
        total++;
        if (on_blank_line != 0) begin
            bad++;
            $display("FAIL de_on_vpos_end: got %0d high clocks expected 0", on_blank_line);
        end
    endtask

    task automatic test_vsync();
        int   low = 0, falls = 0, first_h = -1, first_v = -1, last_h = -1, last_v = -1;
        logic prev = 1'b1;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 2 * B_FRAME; i++) begin
            if (prev && !vsync_b) begin
                falls++;
                if (first_h < 0) begin
                    first_h = int'(hpos_b);
                    first_v = int'(vpos_b);
                end
            end
            if (!vsync_b && falls == 1) begin
                last_h = int'(hpos_b);
                last_v = int'(vpos_b);
            end
            if (!vsync_b) low++;
            prev = vsync_b;
            tick();
        end
        total++;
        if (falls != 2) begin
            bad++;
            $display("FAIL vsync_pulses: got %0d expected 2", falls);
        end
        total++;
        if (low != 2 * BVS * B_LINE) begin
            bad++;
            $display("FAIL vsync_width: got %0d expected %0d", low, 2 * BVS * B_LINE);
        end
        total++;
        if (first_h != 0 || first_v != BVD + BVB) begin
            bad++;
            $display("FAIL vsync_start: got (%0d,%0d) expected (0,%0d)", first_h, first_v, BVD + BVB);
        end
        total++;
        if (last_h != B_LINE - 1 || last_v != BVD + BVB + BVS - 1) begin
            bad++;
            $display("FAIL vsync_end: got (%0d,%0d) expected (%0d,%0d)",
                     last_h, last_v, B_LINE - 1, BVD + BVB + BVS - 1);
        end
    endtask

    task automatic test_frame_wrap();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        repeat (B_FRAME - 1) tick();
        total++;
        if (hpos_b !== 10'(B_LINE - 1) || vpos_b !== 10'(B_LINES - 1)) begin
            bad++;
            $display("FAIL frame_end: got (%0d,%0d) expected (%0d,%0d)",
                     hpos_b, vpos_b, B_LINE - 1, B_LINES - 1);
        end
        tick();
        total++;
        if (hpos_b !== 10'd0 || vpos_b !== 10'd0) begin
            bad++;
            $display("FAIL frame_wrap: got (%0d,%0d) expected (0,0)", hpos_b, vpos_b);
        end
    endtask

    task automatic test_random();
        logic [22:0] got, exp;
        for (int i = 0; i < 4000; i++) begin
            rst_a = ($urandom_range(0, 299) == 0);
            rst_b = ($urandom_range(0, 199) == 0);
            tick();
            got = {hpos_a, vpos_a, hsync_a, vsync_a, de_a};
            exp = model(ta, AHD, AHF, AHS, AHB, AVD, AVB, AVS, AVT);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_a t=%0d: got %h expected %h", ta, got, exp);
            end
            got = {hpos_b, vpos_b, hsync_b, vsync_b, de_b};
            exp = model(tb, BHD, BHF, BHS, BHB, BVD, BVB, BVS, BVT);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_b t=%0d: got %h expected %h", tb, got, exp);
            end
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        test_reset();
        test_line_wrap();
        test_hsync();
        test_display_on();
        test_vsync();
        test_frame_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
